// File: rtl/led_scan_controller_pkg.sv
// Shared definitions for the HUB75 scan sequencer: state encoding and datapath constants.
package led_scan_controller_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RRST   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_BLANK1 = 3'd4;
  localparam logic [2:0] ST_LATCH  = 3'd5;
  localparam logic [2:0] ST_BLANK2 = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RRST   = ST_RRST,
    S_SHIFT  = ST_SHIFT,
    S_FLUSH  = ST_FLUSH,
    S_BLANK1 = ST_BLANK1,
    S_LATCH  = ST_LATCH,
    S_BLANK2 = ST_BLANK2
  } scan_state_e;

  localparam int unsigned BYTES_PER_PIX = 6;

  // Top PWM step; byte 0 never exceeds it (always off), all-ones always does (always on).
  function automatic int unsigned pwm_max(input int unsigned pwm_bits);
    return (32'd1 << pwm_bits) - 32'd2;
  endfunction

endpackage

// File: rtl/led_scan_controller_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
module led_scan_timer #(
  parameter int unsigned W = 3
) (
  input  logic         in_clk,
  input  logic         in_nrst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/led_scan_controller.sv
// HUB75 scan sequencer: per PWM step rewinds the frame FIFO, shifts each row pair,
// then blanks, latches and selects the row. All outputs come straight from flops.
module led_scan_controller
  import led_scan_controller_pkg::*;
#(
  parameter int unsigned COLS      = 64,
  parameter int unsigned ROW_BITS  = 4,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned PIPE_LAT  = 4,
  parameter int unsigned RRST_CYC  = 2,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                in_clk,
  input  logic                in_nrst,
  input  logic                enable,
  input  logic                rx_last_ph,
  output logic                fifo_re_n,
  output logic                fifo_rrst_n,
  output logic                rx_nrst,
  output logic [PWM_BITS-1:0] pwm_value,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                lat,
  output logic                oe_n,
  output logic                frame_done
);

  localparam int unsigned PWM_MAX = pwm_max(PWM_BITS);
  localparam int unsigned TMAX1   = (RRST_CYC > PIPE_LAT) ? RRST_CYC : PIPE_LAT;
  localparam int unsigned TMAX    = (TMAX1 > BLANK_CYC) ? TMAX1 : BLANK_CYC;
  localparam int unsigned TW      = $clog2(TMAX + 1);
  localparam int unsigned PIX_W   = (COLS > 1) ? $clog2(COLS) : 1;

  scan_state_e         state_q, state_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [ROW_BITS-1:0] shift_row_q, shift_row_d;
  logic                step_adv_q, step_adv_d;
  logic [PWM_BITS-1:0] pwm_value_q, pwm_value_d;
  logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
  logic                fifo_re_n_q, fifo_re_n_d;
  logic                fifo_rrst_n_q, fifo_rrst_n_d;
  logic                rx_nrst_q, rx_nrst_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic                frame_done_q, frame_done_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  led_scan_timer #(.W(TW)) u_timer (
    .in_clk   (in_clk),
    .in_nrst  (in_nrst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    shift_row_d = shift_row_q;
    step_adv_d  = step_adv_q;
    pwm_value_d = pwm_value_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      S_IDLE: begin
        // The FIFO is rewound on restart, so the interrupted step restarts from row 0.
        if (enable) begin
          state_d     = S_RRST;
          tmr_load    = 1'b1;
          tmr_val     = TW'(RRST_CYC);
          shift_row_d = '0;
        end
      end
      S_RRST: begin
        if (tmr_done) begin
          state_d = S_SHIFT;
          pix_d   = '0;
        end
      end
      S_SHIFT: begin
        if (rx_last_ph) begin
          if (pix_q == PIX_W'(COLS - 1)) begin
            state_d  = S_FLUSH;
            pix_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = TW'(PIPE_LAT);
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (tmr_done) begin
          state_d  = S_BLANK1;
          tmr_load = 1'b1;
          tmr_val  = TW'(BLANK_CYC);
        end
      end
      S_BLANK1: begin
        if (tmr_done) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        state_d     = S_BLANK2;
        tmr_load    = 1'b1;
        tmr_val     = TW'(BLANK_CYC);
        shift_row_d = shift_row_q + ROW_BITS'(1);
        if (shift_row_q == '1) begin
          step_adv_d = 1'b1;
        end
      end
      S_BLANK2: begin
        if (tmr_done) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (step_adv_q) begin
            state_d  = S_RRST;
            tmr_load = 1'b1;
            tmr_val  = TW'(RRST_CYC);
          end else begin
            state_d = S_SHIFT;
            pix_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A row wrap only flags the step advance; pwm_value moves on RRST entry so it is
    // constant for every shift of a step, even across an enable pause.
    if (state_d == S_RRST && state_q != S_RRST && step_adv_q) begin
      step_adv_d  = 1'b0;
      pwm_value_d = (pwm_value_q == PWM_BITS'(PWM_MAX)) ? '0 : pwm_value_q + PWM_BITS'(1);
    end
  end

  always_comb begin
    fifo_re_n_d   = (state_d != S_SHIFT);
    fifo_rrst_n_d = (state_d != S_RRST);
    rx_nrst_d     = (state_d == S_SHIFT) || (state_d == S_FLUSH);
    lat_d         = (state_d == S_LATCH);
    row_addr_d    = lat_d ? shift_row_q : row_addr_q;
    frame_done_d  = lat_d && (shift_row_q == '1) && (pwm_value_q == PWM_BITS'(PWM_MAX));
    oe_n_d        = oe_n_q;
    case (state_d)
      S_IDLE, S_BLANK1, S_LATCH, S_BLANK2: oe_n_d = 1'b1;
      default: if (state_q == S_BLANK2) oe_n_d = 1'b0;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_q       <= S_IDLE;
      pix_q         <= '0;
      shift_row_q   <= '0;
      step_adv_q    <= 1'b0;
      pwm_value_q   <= '0;
      row_addr_q    <= '0;
      fifo_re_n_q   <= 1'b1;
      fifo_rrst_n_q <= 1'b1;
      rx_nrst_q     <= 1'b0;
      lat_q         <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      shift_row_q   <= shift_row_d;
      step_adv_q    <= step_adv_d;
      pwm_value_q   <= pwm_value_d;
      row_addr_q    <= row_addr_d;
      fifo_re_n_q   <= fifo_re_n_d;
      fifo_rrst_n_q <= fifo_rrst_n_d;
      rx_nrst_q     <= rx_nrst_d;
      lat_q         <= lat_d;
      oe_n_q        <= oe_n_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign fifo_re_n   = fifo_re_n_q;
  assign fifo_rrst_n = fifo_rrst_n_q;
  assign rx_nrst     = rx_nrst_q;
  assign pwm_value   = pwm_value_q;
  assign row_addr    = row_addr_q;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign frame_done  = frame_done_q;

endmodule
